rex_collision_scorer: RTL and testbench

- Sits directly downstream of the game-control block and consumes its rex_y, obs_left and game_state each clk120kHz cycle.
- Detects rex/obstacle overlap and returns a registered hit pulse that the control block uses to enter its over state.
- Keeps a 4-digit BCD run score for the display stage and, optionally, a session high score.

---
 rtl/rex_collision_scorer_pkg.sv | 60 ++++++
 rtl/rex_collision_scorer_bcd_counter4.sv | 63 ++++++
 rtl/rex_collision_scorer.sv | 167 ++++++++++++++++
 tb/tb_rex_collision_scorer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rex_collision_scorer_pkg.sv
// -----------------------------------------------------------------------------
// rex_pkg
// Shared definitions for the rex collision/score block:
//   - game_state codes driven by the game-control block
//   - FSM state encoding for rex_collision_scorer
//   - default sprite geometry
//   - BCD helper functions (decimal-to-BCD constant, digit-wise compare)
// No ports (package).
// -----------------------------------------------------------------------------
package rex_pkg;

    // game_state codes from the control block (2'd2 is unused/illegal)
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } fsm_state_e;

    // Sprite geometry defaults, in pixels
    localparam int REX_X = 16;
    localparam int REX_W = 16;
    localparam int OBS_W = 16;
    localparam int OBS_H = 26;

    // Convert a decimal constant (0..9999) to 4-digit packed BCD
    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] result;
        int          rem;
        result = 16'h0000;
        rem    = value;
        for (int i = 0; i < 4; i++) begin
            result[i*4 +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

    // True when BCD value a is strictly greater than b, compared digit by
    // digit from the thousands digit down
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic decided;
        logic greater;
        decided = 1'b0;
        greater = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                decided = 1'b1;
                greater = (a[i*4 +: 4] > b[i*4 +: 4]);
            end else begin
                decided = decided;
            end
        end
        return greater;
    endfunction

endpackage

// File: rtl/rex_collision_scorer_bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit packed-BCD incrementer with synchronous clear and saturation.
// Ports:
//   clk120kHz  in   system clock
//   rstn       in   asynchronous active-low reset (q -> 0)
//   clr        in   synchronous clear, wins over inc
//   inc        in   add one (BCD, ripple carry between digits)
//   q          out  [15:0] count, q[15:12] is thousands
// -----------------------------------------------------------------------------
module bcd_counter4 #(
    parameter logic [15:0] MAX_BCD = 16'h9999
) (
    input  logic        clk120kHz,
    input  logic        rstn,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] q_r;
    logic [15:0] q_inc_s;
    logic        carry_s;

    // BCD +1 with per-digit carry; holds at MAX_BCD
    always_comb begin
        q_inc_s = q_r;
        carry_s = 1'b1;
        if (q_r == MAX_BCD) begin
            q_inc_s = q_r;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry_s) begin
                    if (q_r[i*4 +: 4] == 4'd9) begin
                        q_inc_s[i*4 +: 4] = 4'd0;
                        carry_s           = 1'b1;
                    end else begin
                        q_inc_s[i*4 +: 4] = q_r[i*4 +: 4] + 4'd1;
                        carry_s           = 1'b0;
                    end
                end else begin
                    q_inc_s[i*4 +: 4] = q_r[i*4 +: 4];
                end
            end
        end
    end

    // Count register
    always_ff @(posedge clk120kHz or negedge rstn) begin
        if (!rstn) begin
            q_r <= 16'h0000;
        end else if (clr) begin
            q_r <= 16'h0000;
        end else if (inc) begin
            q_r <= q_inc_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/rex_collision_scorer.sv
// -----------------------------------------------------------------------------
// rex_collision_scorer
// Detects rex/obstacle overlap, emits a one-cycle registered hit pulse and a
// crashed level, and keeps a 4-digit BCD run score advanced on each rising
// edge of the 6 Hz game tick.
// Optional: define REX_HISCORE_EN to build a session high-score register;
// otherwise hi_score is tied to zero.
// Ports:
//   clk120kHz   in   system clock
//   rstn        in   asynchronous active-low reset
//   clk6Hz      in   6 Hz square wave, synchronous to clk120kHz
//   rex_y       in   [15:0] rex height offset
//   obs_left    in   [15:0] obstacle left x
//   game_state  in   [1:0]  0=init, 1=playing, 3=over
//   hit         out  one-cycle pulse, cycle after first overlapped cycle
//   crashed     out  level, high while in the HIT state
//   score       out  [15:0] BCD run score
//   hi_score    out  [15:0] BCD session best (0 when compiled out)
// -----------------------------------------------------------------------------
module rex_collision_scorer
    import rex_pkg::*;
#(
    parameter int REX_X_P   = REX_X,
    parameter int REX_W_P   = REX_W,
    parameter int OBS_W_P   = OBS_W,
    parameter int OBS_H_P   = OBS_H,
    parameter int SCORE_MAX = 9999
) (
    input  logic        clk120kHz,
    input  logic        rstn,
    input  logic        clk6Hz,
    input  logic [15:0] rex_y,
    input  logic [15:0] obs_left,
    input  logic [1:0]  game_state,
    output logic        hit,
    output logic        crashed,
    output logic [15:0] score,
    output logic [15:0] hi_score
);

    localparam logic [15:0] MAX_BCD   = to_bcd(SCORE_MAX);
    localparam logic [16:0] REX_LEFT  = 17'(REX_X_P);
    localparam logic [16:0] REX_RIGHT = 17'(REX_X_P + REX_W_P);

    fsm_state_e  state_r;
    fsm_state_e  next_s;
    logic        clk6hz_d_r;
    logic        tick_s;
    logic        ov_s;
    logic [16:0] obs_left_x_s;
    logic [16:0] obs_right_s;
    logic        clr_s;
    logic        inc_s;
    logic        hit_next_s;
    logic        crashed_next_s;
    logic        hit_r;
    logic        crashed_r;
    logic [15:0] score_s;

    // Edge history of the 6 Hz input for rising-edge tick detection
    always_ff @(posedge clk120kHz or negedge rstn) begin
        if (!rstn) begin
            clk6hz_d_r <= 1'b0;
        end else begin
            clk6hz_d_r <= clk6Hz;
        end
    end

    assign tick_s = clk6Hz & ~clk6hz_d_r;

    // Overlap test; widened to 17 bits so obs_left + OBS_W cannot wrap
    assign obs_left_x_s = {1'b0, obs_left};
    assign obs_right_s  = obs_left_x_s + 17'(OBS_W_P);
    assign ov_s = (obs_left_x_s < REX_RIGHT) &&
                  (obs_right_s > REX_LEFT) &&
                  (rex_y < 16'(OBS_H_P));

    // Next-state and counter control; init and the illegal code 2 both
    // force IDLE with the score cleared, which also suppresses a hit
    always_comb begin
        next_s = state_r;
        clr_s  = 1'b0;
        inc_s  = 1'b0;
        if ((game_state == ST_INIT) || (game_state == 2'd2)) begin
            next_s = IDLE;
            clr_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    clr_s = 1'b1;
                    if (game_state == ST_PLAYING) begin
                        next_s = RUN;
                    end else begin
                        next_s = IDLE;
                    end
                end
                RUN: begin
                    // collision takes priority over a same-cycle tick
                    if (ov_s) begin
                        next_s = HIT;
                    end else if (tick_s) begin
                        inc_s = 1'b1;
                    end else begin
                        next_s = RUN;
                    end
                end
                HIT: begin
                    next_s = HIT;
                end
                default: begin
                    next_s = IDLE;
                    clr_s  = 1'b1;
                end
            endcase
        end
    end

    assign hit_next_s     = (state_r == RUN) && (next_s == HIT);
    assign crashed_next_s = (next_s == HIT);

    // FSM state and registered hit/crashed outputs
    always_ff @(posedge clk120kHz or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            hit_r     <= 1'b0;
            crashed_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            hit_r     <= hit_next_s;
            crashed_r <= crashed_next_s;
        end
    end

    bcd_counter4 #(
        .MAX_BCD (MAX_BCD)
    ) u_score (
        .clk120kHz (clk120kHz),
        .rstn      (rstn),
        .clr       (clr_s),
        .inc       (inc_s),
        .q         (score_s)
    );

`ifdef REX_HISCORE_EN
    logic [15:0] hi_score_r;

    // Session best, captured at the moment of collision; only rstn clears it
    always_ff @(posedge clk120kHz or negedge rstn) begin
        if (!rstn) begin
            hi_score_r <= 16'h0000;
        end else if (hit_next_s && bcd_gt(score_s, hi_score_r)) begin
            hi_score_r <= score_s;
        end else begin
            hi_score_r <= hi_score_r;
        end
    end

    assign hi_score = hi_score_r;
`else
    assign hi_score = 16'h0000;
`endif

    assign hit     = hit_r;
    assign crashed = crashed_r;
    assign score   = score_s;

endmodule

// File: tb/tb_rex_collision_scorer.sv
// -----------------------------------------------------------------------------
// tb_rex_collision_scorer
// Directed self-checking bench for rex_collision_scorer. Inputs change 1 ns
// after a rising clock edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_rex_collision_scorer;

    logic        clk120kHz;
    logic        rstn;
    logic        clk6Hz;
    logic [15:0] rex_y;
    logic [15:0] obs_left;
    logic [1:0]  game_state;
    logic        hit;
    logic        crashed;
    logic [15:0] score;
    logic [15:0] hi_score;

    int vectors;
    int miscompares;

`ifdef REX_HISCORE_EN
    localparam logic [15:0] HI_41 = 16'h0041;
    localparam logic [15:0] HI_57 = 16'h0057;
`else
    localparam logic [15:0] HI_41 = 16'h0000;
    localparam logic [15:0] HI_57 = 16'h0000;
`endif

    rex_collision_scorer dut (
        .clk120kHz  (clk120kHz),
        .rstn       (rstn),
        .clk6Hz     (clk6Hz),
        .rex_y      (rex_y),
        .obs_left   (obs_left),
        .game_state (game_state),
        .hit        (hit),
        .crashed    (crashed),
        .score      (score),
        .hi_score   (hi_score)
    );

    initial clk120kHz = 1'b0;
    always #5 clk120kHz = ~clk120kHz;

    task automatic step();
        @(posedge clk120kHz);
        #1;
    endtask

    // one 6 Hz rising edge followed by the low phase
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk6Hz = 1'b1;
            step();
            clk6Hz = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        clk6Hz      = 1'b0;
        rex_y       = 16'd0;
        obs_left    = 16'd100;
        game_state  = 2'd0;
        step();
        step();
        chk("rst_hit", {15'd0, hit}, 16'd0);
        chk("rst_crashed", {15'd0, crashed}, 16'd0);
        chk("rst_score", score, 16'h0000);
        chk("rst_hi", hi_score, 16'h0000);
        rstn = 1'b1;
        step();

        // near misses: rex too high, right edge exclusive, left edge exclusive
        game_state = 2'd1;
        rex_y      = 16'd27;
        obs_left   = 16'd24;
        step();
        step();
        chk("miss_high_hit", {15'd0, hit}, 16'd0);
        chk("miss_high_crashed", {15'd0, crashed}, 16'd0);
        rex_y    = 16'd0;
        obs_left = 16'd32;
        step();
        chk("miss_right_hit", {15'd0, hit}, 16'd0);
        obs_left = 16'd0;
        step();
        chk("miss_left_hit", {15'd0, hit}, 16'd0);
        chk("miss_left_crashed", {15'd0, crashed}, 16'd0);

        // counting
        obs_left = 16'd100;
        ticks(12);
        chk("score_12", score, 16'h0012);
        ticks(29);
        chk("score_41", score, 16'h0041);

        // tick and overlap in the same cycle
        obs_left = 16'd24;
        clk6Hz   = 1'b1;
        chk("pre_hit", {15'd0, hit}, 16'd0);
        step();
        chk("hit_pulse", {15'd0, hit}, 16'd1);
        chk("hit_crashed", {15'd0, crashed}, 16'd1);
        chk("hit_score", score, 16'h0041);
        clk6Hz = 1'b0;
        step();
        chk("hit_drop", {15'd0, hit}, 16'd0);
        chk("hit_crashed_held", {15'd1 & 15'd0, crashed}, 16'd1);
        ticks(1);
        chk("hit_frozen", score, 16'h0041);
        chk("hit_no_repeat", {15'd0, hit}, 16'd0);
        game_state = 2'd3;
        step();
        chk("over_crashed", {15'd0, crashed}, 16'd1);
        game_state = 2'd0;
        step();
        chk("init_crashed", {15'd0, crashed}, 16'd0);
        chk("init_score", score, 16'h0000);
        chk("hi_after_41", hi_score, HI_41);

        // high score across two runs
        game_state = 2'd1;
        obs_left   = 16'd100;
        step();
        ticks(57);
        chk("score_57", score, 16'h0057);
        obs_left = 16'd24;
        step();
        chk("hit_57", {15'd0, hit}, 16'd1);
        chk("hi_57", hi_score, HI_57);
        game_state = 2'd3;
        step();
        game_state = 2'd0;
        step();
        chk("hi_survives", hi_score, HI_57);
        chk("restart_score", score, 16'h0000);
        game_state = 2'd1;
        obs_left   = 16'd100;
        step();
        ticks(33);
        chk("score_33", score, 16'h0033);
        obs_left = 16'd24;
        step();
        chk("hit_33", {15'd0, hit}, 16'd1);
        chk("hi_kept", hi_score, HI_57);
        chk("score_33_frozen", score, 16'h0033);

        // init and overlap together: no hit
        game_state = 2'd0;
        step();
        game_state = 2'd1;
        obs_left   = 16'd100;
        step();
        ticks(1);
        chk("score_1", score, 16'h0001);
        game_state = 2'd0;
        obs_left   = 16'd24;
        step();
        chk("init_ov_hit", {15'd0, hit}, 16'd0);
        chk("init_ov_score", score, 16'h0000);

        // illegal game_state clears crashed
        obs_left   = 16'd100;
        game_state = 2'd1;
        step();
        obs_left = 16'd24;
        step();
        chk("crash_again", {15'd0, crashed}, 16'd1);
        game_state = 2'd2;
        step();
        chk("illegal_crashed", {15'd0, crashed}, 16'd0);

        // asynchronous reset during HIT
        game_state = 2'd1;
        obs_left   = 16'd100;
        step();
        ticks(1);
        obs_left = 16'd24;
        step();
        chk("pre_rst_hit", {15'd0, hit}, 16'd1);
        step();
        rstn = 1'b0;
        #1;
        chk("async_crashed", {15'd0, crashed}, 16'd0);
        chk("async_score", score, 16'h0000);
        chk("async_hit", {15'd0, hit}, 16'd0);
        chk("async_hi", hi_score, 16'h0000);
        obs_left = 16'd100;
        step();
        rstn = 1'b1;
        step();
        ticks(1);
        chk("resume_score", score, 16'h0001);
        chk("resume_hit", {15'd0, hit}, 16'd0);

        // saturation at 9999
        game_state = 2'd0;
        step();
        game_state = 2'd1;
        step();
        ticks(9998);
        chk("score_9998", score, 16'h9998);
        ticks(3);
        chk("score_sat", score, 16'h9999);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
